// File: rtl/psum_acc_seq.sv
// rtl/psum_acc_seq.sv - pmem partial-sum accumulation sequencer with SIMD/16-bit modes and ReLU
module psum_acc_seq #(
    parameter int COL        = 8,
    parameter int PSUM_BW    = 16,
    parameter int LEN_KIJ    = 9,
    parameter int N_OUT      = 8,
    parameter int ROW_STRIDE = 20,
    parameter int ROW_OFFSET = 10,
    parameter int ADDR_BW    = 11
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_start,
    input  logic                     i_simd_en,
    input  logic                     i_relu_en,
    input  logic [COL*PSUM_BW-1:0]   i_pmem_rdata,
    output logic                     o_pmem_cen,
    output logic                     o_pmem_wen,
    output logic [ADDR_BW-1:0]       o_pmem_addr,
    output logic                     o_busy,
    output logic                     o_out_valid,
    output logic [COL*PSUM_BW-1:0]   o_out_data,
    output logic [2:0]               o_out_row,
    output logic                     o_done
);

    localparam int HALF = PSUM_BW / 2;
    localparam int KW   = $clog2(LEN_KIJ);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_EMIT,
        S_DONE
    } state_t;

    state_t                         r_state;
    state_t                         w_next;
    logic [KW-1:0]                  r_k;
    logic [2:0]                     r_o;
    logic                           r_simd;
    logic                           r_relu;
    logic [ADDR_BW-1:0]             r_base;
    logic [ADDR_BW-1:0]             r_addr;
    logic                           r_cen;
    logic [COL-1:0][PSUM_BW-1:0]    r_acc0;
    logic [COL-1:0][PSUM_BW-1:0]    r_acc1;
    logic [COL-1:0][PSUM_BW-1:0]    r_out_data;
    logic                           r_out_valid;
    logic [2:0]                     r_out_row;
    logic [COL-1:0][PSUM_BW-1:0]    w_word;
    logic [COL-1:0][PSUM_BW-1:0]    w_sum0;
    logic [COL-1:0][PSUM_BW-1:0]    w_sum1;
    logic [COL-1:0][PSUM_BW-1:0]    w_result;
    logic                           w_last_k;
    logic                           w_last_o;

    assign w_word      = i_pmem_rdata;
    assign w_last_k    = (r_k == KW'(LEN_KIJ - 1));
    assign w_last_o    = (r_o == 3'(N_OUT - 1));

    assign o_pmem_cen  = r_cen;
    assign o_pmem_wen  = 1'b1;
    assign o_pmem_addr = r_addr;
    assign o_busy      = (r_state != S_IDLE);
    assign o_done      = (r_state == S_DONE);
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_out_row   = r_out_row;

    // State register; reset forces IDLE at once, aborting any read in flight
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode: 9 ISSUE, 1 DRAIN, 1 EMIT per row, then one DONE cycle
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_next = S_ISSUE;
            S_ISSUE: if (w_last_k) w_next = S_DRAIN;
            S_DRAIN: w_next = S_EMIT;
            S_EMIT:  w_next = w_last_o ? S_DONE : S_ISSUE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Per-column add of the incoming word: split into signed lanes in SIMD mode, full width otherwise
    always_comb begin
        w_sum0   = r_acc0;
        w_sum1   = r_acc1;
        w_result = '0;
        for (int c = 0; c < COL; c++) begin
            if (r_simd) begin
                w_sum0[c] = r_acc0[c] + {{HALF{w_word[c][HALF-1]}}, w_word[c][HALF-1:0]};
                w_sum1[c] = r_acc1[c] + {{HALF{w_word[c][PSUM_BW-1]}}, w_word[c][PSUM_BW-1:HALF]};
            end else begin
                w_sum0[c] = r_acc0[c] + w_word[c];
            end
            w_result[c] = w_sum0[c] + w_sum1[c];
            if (r_relu && w_result[c][PSUM_BW-1]) begin
                w_result[c] = '0;
            end
        end
    end

    // Counters, pmem control, accumulators and the registered result vector
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_k         <= '0;
            r_o         <= '0;
            r_simd      <= 1'b0;
            r_relu      <= 1'b0;
            r_base      <= '0;
            r_addr      <= '0;
            r_cen       <= 1'b1;
            r_acc0      <= '0;
            r_acc1      <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_row   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_simd <= i_simd_en;
                        r_relu <= i_relu_en;
                        r_o    <= '0;
                        r_k    <= '0;
                        r_acc0 <= '0;
                        r_acc1 <= '0;
                        r_base <= ADDR_BW'(ROW_OFFSET);
                        r_addr <= ADDR_BW'(ROW_OFFSET);
                        r_cen  <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    // the word read in the previous ISSUE cycle arrives now
                    if (r_k != '0) begin
                        r_acc0 <= w_sum0;
                        r_acc1 <= w_sum1;
                    end
                    if (w_last_k) begin
                        r_cen <= 1'b1;
                    end else begin
                        r_k    <= r_k + KW'(1);
                        r_addr <= r_addr + ADDR_BW'(1);
                    end
                end
                S_DRAIN: begin
                    r_acc0      <= w_sum0;
                    r_acc1      <= w_sum1;
                    r_out_data  <= w_result;
                    r_out_row   <= r_o;
                    r_out_valid <= 1'b1;
                end
                S_EMIT: begin
                    r_out_valid <= 1'b0;
                    r_acc0      <= '0;
                    r_acc1      <= '0;
                    r_k         <= '0;
                    if (!w_last_o) begin
                        r_o    <= r_o + 3'd1;
                        r_base <= r_base + ADDR_BW'(ROW_STRIDE);
                        r_addr <= r_base + ADDR_BW'(ROW_STRIDE);
                        r_cen  <= 1'b0;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_psum_acc_seq.sv
// tb/tb_psum_acc_seq.sv - table-driven bench for psum_acc_seq with a 1-cycle pmem model
module tb_psum_acc_seq;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         simd_en = 1'b0;
    logic         relu_en = 1'b0;
    logic [127:0] pmem_rdata = '0;
    logic         pmem_cen;
    logic         pmem_wen;
    logic [10:0]  pmem_addr;
    logic         busy;
    logic         out_valid;
    logic [127:0] out_data;
    logic [2:0]   out_row;
    logic         done;

    int total = 0;
    int bad   = 0;

    logic [15:0] m_fill  = '0;
    logic [15:0] m_cstep = '0;
    logic        m_amix  = 1'b0;

    typedef struct {
        logic        simd;
        logic        relu;
        logic [15:0] fill;
        logic [15:0] cstep;
        logic        amix;
        logic [15:0] base;
        logic [15:0] ecstep;
        logic [15:0] erstep;
    } vec_t;

    vec_t tbl[10];

    psum_acc_seq dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_start      (start),
        .i_simd_en    (simd_en),
        .i_relu_en    (relu_en),
        .i_pmem_rdata (pmem_rdata),
        .o_pmem_cen   (pmem_cen),
        .o_pmem_wen   (pmem_wen),
        .o_pmem_addr  (pmem_addr),
        .o_busy       (busy),
        .o_out_valid  (out_valid),
        .o_out_data   (out_data),
        .o_out_row    (out_row),
        .o_done       (done)
    );

    always #5 clk = ~clk;

    // pmem model: word per column is fill + c*cstep, or the address itself; zero when not read
    always @(posedge clk) begin
        if (!pmem_cen) begin
            for (int c = 0; c < 8; c++) begin
                pmem_rdata[c*16 +: 16] <= m_amix ? 16'(pmem_addr) : m_fill + 16'(c) * m_cstep;
            end
        end else begin
            pmem_rdata <= '0;
        end
    end

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_ctl"}, {pmem_cen, pmem_wen, pmem_addr, busy, out_valid, out_row, done},
              {1'b1, 1'b1, 11'd0, 1'b0, 1'b0, 3'd0, 1'b0});
        check({name, "_data"}, out_data, 160'd0);
    endtask

    task automatic run(input int i, input int restart_at, input int reset_at);
        int           n;
        int           next_row;
        int           addr_err;
        int           ctl_err;
        int           reads;
        int           ph;
        bit           fin;
        logic [127:0] ev;
        m_fill  = tbl[i].fill;
        m_cstep = tbl[i].cstep;
        m_amix  = tbl[i].amix;
        simd_en = tbl[i].simd;
        relu_en = tbl[i].relu;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        n = 1;
        #1;
        start   = 1'b0;
        simd_en = ~simd_en;
        relu_en = ~relu_en;
        next_row = 0;
        addr_err = 0;
        ctl_err  = 0;
        reads    = 0;
        fin      = 1'b0;
        while (!fin) begin
            @(negedge clk);
            if (reset_at != 0 && n == reset_at) begin
                reset = 1'b1;
                #1;
                check_reset_outputs("reset_abort");
                @(negedge clk);
                check_reset_outputs("reset_hold");
                reset = 1'b0;
                return;
            end
            start = (restart_at != 0 && n == restart_at - 1);
            ph = (n - 1) % 11;
            if (!pmem_cen) begin
                reads++;
                if (ph >= 9 || pmem_addr !== 11'(20 * ((n - 1) / 11) + 10 + ph) || pmem_addr >= 11'd170)
                    addr_err++;
            end
            if (out_valid) begin
                for (int c = 0; c < 8; c++)
                    ev[c*16 +: 16] = tbl[i].base + 16'(c) * tbl[i].ecstep + 16'(next_row) * tbl[i].erstep;
                check("row_idx", 160'(out_row), 160'(next_row));
                check("row_time", 160'(n), 160'(11 + 11 * next_row));
                check("row_data", out_data, ev);
                next_row++;
            end
            if (done) begin
                check("done_time", 160'(n), 160'd89);
                check("rows_seen", 160'(next_row), 160'd8);
                check("addr_seq", 160'(addr_err), 160'd0);
                check("read_count", 160'(reads), 160'd72);
                check("busy_run", 160'(ctl_err), 160'd0);
                @(negedge clk);
                check("busy_drop", 160'({busy, done}), 160'd0);
                fin = 1'b1;
            end else if (n > 120) begin
                check("timeout", 160'(n), 160'd89);
                fin = 1'b1;
            end else if (!busy || pmem_wen !== 1'b1) begin
                ctl_err++;
            end
            if (!fin) begin
                @(posedge clk);
                n++;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        //         simd  relu  fill      cstep     amix  base      ecstep   erstep
        tbl[0] = '{1'b1, 1'b0, 16'h0201, 16'h0000, 1'b0, 16'h001B, 16'd0,   16'd0};
        tbl[1] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 16'hFFEE, 16'd0,   16'd0};
        tbl[2] = '{1'b1, 1'b1, 16'hFFFF, 16'h0000, 1'b0, 16'h0000, 16'd0,   16'd0};
        tbl[3] = '{1'b0, 1'b0, 16'h0100, 16'h0000, 1'b0, 16'h0900, 16'd0,   16'd0};
        tbl[4] = '{1'b0, 1'b0, 16'h7000, 16'h0000, 1'b0, 16'hF000, 16'd0,   16'd0};
        tbl[5] = '{1'b0, 1'b1, 16'h7000, 16'h0000, 1'b0, 16'h0000, 16'd0,   16'd0};
        tbl[6] = '{1'b0, 1'b0, 16'h0001, 16'h0001, 1'b0, 16'd9,    16'd9,   16'd0};
        tbl[7] = '{1'b1, 1'b0, 16'h0201, 16'h0101, 1'b0, 16'h001B, 16'd18,  16'd0};
        tbl[8] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'd126,  16'd0,   16'd180};
        tbl[9] = '{1'b1, 1'b1, 16'h0201, 16'h0000, 1'b0, 16'h001B, 16'd0,   16'd0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset_state");
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run(i, 0, 0);
        end

        run(0, 20, 0);
        run(7, 0, 30);
        run(7, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/psum_acc_seq.md
# psum_acc_seq

Accumulation sequencer between the partial-sum SRAM (pmem) and the output path of the SIMD core. On `start` it walks every output row and reads the nine per-kij partial-sum words for that row from pmem. It accumulates them per column, in either SIMD mode (two signed 8-bit lanes per 16-bit word) or full-width mode, applies optional ReLU, and emits one result vector per row. This hardware stage replaces the bench-driven acc/A_pmem stimulus used today.

## Interface
- `col`, 8, number of output columns (16-bit words per pmem line)
- `psum_bw`, 16, partial-sum word width per column
- `len_kij`, 9, number of kij words accumulated per output row
- `n_out`, 8, number of output rows per run
- `row_stride`, 20, pmem address stride between output rows
- `row_offset`, 10, pmem address offset of kij 0 within a row
- `addr_bw`, 11, pmem address width

- `clk`  in  1  single clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-high; forces the block to IDLE
- `start`  in  1  begins a run when sampled high in IDLE; ignored otherwise
- `simd_en`  in  1  1 = dual 8-bit lane mode; 0 = 16-bit mode; sampled with `start`
- `relu_en`  in  1  1 = clamp negative results to 0; sampled with `start`
- `pmem_rdata`  in  col*psum_bw  pmem read data, valid one cycle after a read is issued
- `pmem_cen`  out  1  pmem chip enable, active-low, registered
- `pmem_wen`  out  1  pmem write enable, active-low; tied to 1 (block never writes)
- `pmem_addr`  out  addr_bw  pmem read address, registered
- `busy`  out  1  high in every state except IDLE
- `out_valid`  out  1  one-cycle strobe; `out_data` and `out_row` are valid while it is high
- `out_data`  out  col*psum_bw  per-column result; column c occupies bits [c*16 +: 16]
- `out_row`  out  3  index of the output row carried by `out_data`
- `done`  out  1  one-cycle pulse after the last row is emitted

## Operation
- FSM states: IDLE, ISSUE, DRAIN, EMIT, DONE.
- IDLE → ISSUE when `start`=1: latch `simd_en`/`relu_en`, set o=0, k=0, clear the accumulators.
- ISSUE (len_kij cycles):
  - Each cycle presents `pmem_cen`=0 and `pmem_addr` = o*row_stride + row_offset + k, with k counting 0..len_kij-1.
  - Every ISSUE cycle with k≥1 captures `pmem_rdata` from the previous cycle's read into the accumulators.
  - After k = len_kij-1 → DRAIN.
- DRAIN (1 cycle):
  - `pmem_cen`=1.
  - Captures the last word.
  - At the end of the cycle, registers `out_data` from (accumulator + last word), `out_row`=o and `out_valid`=1. → EMIT.
- EMIT (1 cycle):
  - `out_valid`=1.
  - Accumulators are cleared, k=0.
  - If o < n_out-1: o←o+1 and → ISSUE; otherwise → DONE.
- DONE (1 cycle): `done`=1 → IDLE.
- Arithmetic for SIMD mode, per column:
  - lane0 = word[7:0] and lane1 = word[15:8], both signed.
  - Each lane is sign-extended into its own 16-bit signed accumulator.
  - Result = lane0_acc + lane1_acc, truncated to 16 bits (two's-complement wrap).
- Arithmetic for 16-bit mode: a 16-bit signed accumulator per column, wrapping modulo 2^16.
- ReLU, when enabled: a result with bit 15 set becomes 0x0000. It is applied after the lane combine and after the wrap.
- `start` while `busy`: ignored, with no effect on the counters or mode bits.
- `simd_en`/`relu_en` changes mid-run: no effect until the next `start`.

## Timing
- Reset values:
  - `pmem_cen`=1, `pmem_wen`=1, `pmem_addr`=0
  - `busy`=0, `out_valid`=0, `out_data`=0, `out_row`=0, `done`=0
  - State IDLE, with all counters and accumulators zeroed.
- Reset asserted mid-run: the next read is aborted immediately. Outputs take their reset values asynchronously and no partial row is emitted.
- pmem read latency is fixed at 1 cycle: an address presented in cycle n returns data sampled at the end of cycle n+1.
- Row period is 11 cycles: 9 ISSUE + 1 DRAIN + 1 EMIT.
- `start` sampled at edge E0 puts the first ISSUE cycle at E0+1 and the first `out_valid` cycle at E0+11.
- Subsequent `out_valid` pulses occur every 11 cycles.
- `done` is high in the cycle immediately after the last EMIT; `busy` drops the cycle after `done`.
- Total run: 1 + n_out*11 cycles from `start` to `done` inclusive, which is 89 cycles at the defaults.

## Test plan
- Address check: pmem model logs reads during a default run. Row 3 must read addresses 70..78 in consecutive cycles, and no address ≥ 170 may ever be read.
- SIMD sum: every pmem word = 0x0201, `simd_en`=1, `relu_en`=0. Every column of every row must be 0x001B, with `out_row` running 0..7 at an 11-cycle spacing.
- Negative and ReLU: every word = 0xFFFF, `simd_en`=1.
  - With `relu_en`=0, every column must be 0xFFEE.
  - With `relu_en`=1, every column must be 0x0000.
- 16-bit mode and wrap: `simd_en`=0.
  - Every word = 0x0100: every column must be 0x0900.
  - Every word = 0x7000: every column must be 0xF000, or 0x0000 with `relu_en`=1.
- Control robustness:
  - Pulse `start` again at cycle 20 of a run: the row sequence must be unchanged and `done` must still fall at cycle 89.
  - Assert `reset` at cycle 30: all outputs must immediately take their reset values, and a new `start` must rerun cleanly from row 0.
